// File: rtl/uart_prog_loader_if.sv
// RAM write-port bundle driven by the serial program loader.
// The loader is the master; the instruction/data RAM is the slave.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport slave (
    input mem_addr,
    input mem_wdata,
    input mem_we
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver plus framed image loader that fills the CPU RAM
// with big-endian 16-bit words and holds the CPU in reset meanwhile.
module uart_prog_loader #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  uart_prog_loader_if.master mem,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 2);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [16:0]   CAP      = 17'(1) << ADDR_W;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    WAIT_HDR, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK
  } ld_state_t;

  logic            s1, s2;
  rx_state_t       rx_st, rx_st_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, sh_n;
  logic            byte_valid, bv_n;
  logic            frame_err, fe_n;

  ld_state_t       ld, ld_n;
  logic [15:0]     n_q, n_n;
  logic [15:0]     n_full;
  logic [7:0]      hi_q, hi_n;
  logic [7:0]      chk_q, chk_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [15:0]     wdata_q, wdata_n;
  logic            we_q, we_n;
  logic            hold_q, hold_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic [15:0]     words_q, words_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      rx_st      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      ld         <= WAIT_HDR;
      n_q        <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
    end else begin
      s1         <= rx;
      s2         <= s1;
      rx_st      <= rx_st_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= sh_n;
      byte_valid <= bv_n;
      frame_err  <= fe_n;
      ld         <= ld_n;
      n_q        <= n_n;
      hi_q       <= hi_n;
      chk_q      <= chk_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      we_q       <= we_n;
      hold_q     <= hold_n;
      done_q     <= done_n;
      err_q      <= err_n;
      words_q    <= words_n;
    end
  end

  // Start bit is re-checked near mid-bit to reject short glitches.
  always_comb begin
    rx_st_n = rx_st;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    bv_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        if (!s2) begin
          rx_st_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          bit_n   = '0;
          rx_st_n = s2 ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          sh_n  = {s2, shreg[7:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_st_n = RX_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          rx_st_n = RX_IDLE;
          bv_n    = s2;
          fe_n    = !s2;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
  end

  assign n_full = {n_q[15:8], shreg};

  always_comb begin
    ld_n    = ld;
    n_n     = n_q;
    hi_n    = hi_q;
    chk_n   = chk_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    we_n    = 1'b0;
    hold_n  = hold_q;
    done_n  = done_q;
    err_n   = err_q;
    words_n = words_q;
    // The cycle after a write strobe advances the word pointer.
    if (we_q) begin
      addr_n  = addr_q + ADDR_W'(1);
      words_n = words_q + 16'd1;
      ld_n    = (words_q + 16'd1 == n_q) ? CHECK : DATA_HI;
    end
    unique case (1'b1)
      frame_err && ld != WAIT_HDR: begin
        err_n  = 1'b1;
        hold_n = 1'b0;
        ld_n   = WAIT_HDR;
      end
      byte_valid: begin
        unique case (ld)
          WAIT_HDR: begin
            if (shreg == 8'hA5) begin
              hold_n  = 1'b1;
              done_n  = 1'b0;
              err_n   = 1'b0;
              words_n = '0;
              addr_n  = '0;
              chk_n   = '0;
              ld_n    = CNT_HI;
            end
          end
          CNT_HI: begin
            n_n   = {shreg, n_q[7:0]};
            chk_n = chk_q ^ shreg;
            ld_n  = CNT_LO;
          end
          CNT_LO: begin
            n_n   = n_full;
            chk_n = chk_q ^ shreg;
            if (n_full == 16'd0) begin
              ld_n = CHECK;
            end else if ({1'b0, n_full} > CAP) begin
              err_n  = 1'b1;
              hold_n = 1'b0;
              ld_n   = WAIT_HDR;
            end else begin
              ld_n = DATA_HI;
            end
          end
          DATA_HI: begin
            hi_n  = shreg;
            chk_n = chk_q ^ shreg;
            ld_n  = DATA_LO;
          end
          DATA_LO: begin
            chk_n   = chk_q ^ shreg;
            wdata_n = {hi_q, shreg};
            we_n    = 1'b1;
          end
          CHECK: begin
            if (shreg == chk_q) done_n = 1'b1;
            else                err_n  = 1'b1;
            hold_n = 1'b0;
            ld_n   = WAIT_HDR;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_loaded  = words_q;

endmodule
